// File: rtl/lcd_bus_rx_if.sv
// HD44780 8-bit write bus as seen between the LCD controller and its receiver.
interface lcd_bus_rx_if;
  logic       E;
  logic       RS;
  logic [7:0] data;

  modport master (output E, RS, data);
  modport slave  (input  E, RS, data);
endinterface

// File: rtl/lcd_bus_rx.sv
// HD44780 write-bus receiver: captures E-falling transfers, keeps a 2x16 character shadow,
// emulates busy timing and flags protocol errors. Define LCD_RX_SYNC_EN to synchronise the bus inputs.
module lcd_bus_rx #(
  parameter int MIN_E_HIGH = 12,
  parameter int BUSY_CYC   = 2000,
  parameter int CLR_CYC    = 76500
) (
  input  logic         i_board_clk,
  input  logic         i_rst,
  lcd_bus_rx_if.slave  i_bus,
  input  logic         i_err_clr,
  input  logic [4:0]   i_rd_idx,
  output logic [7:0]   o_rd_char,
  output logic         o_valid,
  output logic         o_rs,
  output logic [7:0]   o_byte,
  output logic [6:0]   o_cursor,
  output logic         o_busy,
  output logic         o_err_short_e,
  output logic         o_err_busy
);

  localparam int HC_W = $clog2(MIN_E_HIGH + 1) + 1;
  localparam int BMAX = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
  localparam int BC_W = $clog2(BMAX + 1);
  localparam logic [HC_W-1:0] MIN_HC  = HC_W'(MIN_E_HIGH);
  localparam logic [BC_W-1:0] BUSY_LD = BC_W'(BUSY_CYC - 1);
  localparam logic [BC_W-1:0] CLR_LD  = BC_W'(CLR_CYC - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

  function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Visible lines are 0x00-0x27 and 0x40-0x67; stepping across their ends jumps to the other line.
  function automatic logic [6:0] cur_step(input logic [6:0] c, input logic inc);
    logic [6:0] n;
    if (inc) n = (c == 7'h27) ? 7'h40 : (c == 7'h67) ? 7'h00 : c + 7'd1;
    else     n = (c == 7'h00) ? 7'h67 : (c == 7'h40) ? 7'h27 : c - 7'd1;
    return n;
  endfunction

  logic       w_E, w_RS;
  logic [7:0] w_data;

`ifdef LCD_RX_SYNC_EN
  logic       r_E_p1, r_E_p2, r_RS_p1, r_RS_p2;
  logic [7:0] r_data_p1, r_data_p2;
  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      r_E_p1 <= 1'b0;
      r_E_p2 <= 1'b0;
    end else begin
      r_E_p1 <= i_bus.E;
      r_E_p2 <= r_E_p1;
    end
    r_RS_p1   <= i_bus.RS;
    r_RS_p2   <= r_RS_p1;
    r_data_p1 <= i_bus.data;
    r_data_p2 <= r_data_p1;
  end
  assign w_E    = r_E_p2;
  assign w_RS   = r_RS_p2;
  assign w_data = r_data_p2;
`else
  assign w_E    = i_bus.E;
  assign w_RS   = i_bus.RS;
  assign w_data = i_bus.data;
`endif

  logic            r_E_d, r_rs_l, r_id;
  logic [7:0]      r_data_l;
  logic [HC_W-1:0] r_hcnt;
  logic [BC_W-1:0] r_bcnt;
  logic [4:0]      r_sweep;
  logic [6:0]      r_cursor;
  logic [7:0]      r_shadow [32];
  state_t          r_state, w_state_nxt;
  logic            w_fall, w_short, w_xfer, w_accept, w_is_clr, w_wr_en;
  logic            w_sweep_we, w_ld_busy, w_ld_clr, w_cnt_dec;
  logic [4:0]      w_wr_idx;

  // E edge detection and capture of the last bus value seen while E was high
  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      r_E_d  <= 1'b0;
      r_hcnt <= '0;
    end else begin
      r_E_d  <= w_E;
      r_hcnt <= w_E ? sat_inc(r_hcnt) : '0;
    end
    if (w_E) begin
      r_rs_l   <= w_RS;
      r_data_l <= w_data;
    end
  end

  assign w_fall   = r_E_d & ~w_E;
  assign w_short  = w_fall & (r_hcnt < MIN_HC);
  assign w_xfer   = w_fall & ~w_short;
  assign o_busy   = (r_state != S_IDLE);
  assign w_accept = w_xfer & ~o_busy;
  assign w_is_clr = ~r_rs_l & (r_data_l == 8'h01);
  assign w_wr_en  = w_accept & r_rs_l & (r_cursor[5:4] == 2'b00);
  assign w_wr_idx = {r_cursor[6], r_cursor[3:0]};
  assign o_cursor = r_cursor;

  always_ff @(posedge i_board_clk) begin
    if (i_rst) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_we  = 1'b0;
    w_ld_busy   = 1'b0;
    w_ld_clr    = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_sweep_we = 1'b1;
        if (r_sweep == 5'd31) begin
          w_state_nxt = S_BUSY;
          w_ld_clr    = 1'b1;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_clr) w_state_nxt = S_CLEAR;
          else begin
            w_state_nxt = S_BUSY;
            w_ld_busy   = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (r_bcnt == '0) w_state_nxt = S_IDLE;
        else              w_cnt_dec   = 1'b1;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      r_sweep <= '0;
      r_bcnt  <= '0;
    end else begin
      if (w_sweep_we) r_sweep <= r_sweep + 5'd1;
      if (w_ld_clr)       r_bcnt <= CLR_LD;
      else if (w_ld_busy) r_bcnt <= BUSY_LD;
      else if (w_cnt_dec) r_bcnt <= r_bcnt - 1'b1;
    end
  end

  // Command decode: the highest set bit selects the instruction
  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      r_cursor <= '0;
      r_id     <= 1'b1;
    end else if (w_accept) begin
      if (r_rs_l) r_cursor <= cur_step(r_cursor, r_id);
      else begin
        casez (r_data_l)
          8'b1???????: r_cursor <= r_data_l[6:0];
          8'b0001????: if (!r_data_l[3]) r_cursor <= cur_step(r_cursor, r_data_l[2]);
          8'b000001??: r_id <= r_data_l[1];
          8'b0000001?: r_cursor <= '0;
          8'b00000001: begin
            r_cursor <= '0;
            r_id     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_board_clk) begin
    if (w_sweep_we)   r_shadow[r_sweep]  <= 8'h20;
    else if (w_wr_en) r_shadow[w_wr_idx] <= r_data_l;
  end

  always_ff @(posedge i_board_clk) begin
    if (i_rst) begin
      o_rd_char     <= '0;
      o_valid       <= 1'b0;
      o_rs          <= 1'b0;
      o_byte        <= '0;
      o_err_short_e <= 1'b0;
      o_err_busy    <= 1'b0;
    end else begin
      o_rd_char <= r_shadow[i_rd_idx];
      o_valid   <= w_xfer;
      if (w_xfer) begin
        o_rs   <= r_rs_l;
        o_byte <= r_data_l;
      end
      if (w_short)        o_err_short_e <= 1'b1;
      else if (i_err_clr) o_err_short_e <= 1'b0;
      if (w_xfer && o_busy) o_err_busy <= 1'b1;
      else if (i_err_clr)   o_err_busy <= 1'b0;
    end
  end

endmodule
